// File: rtl/roi_binomial_blur.sv
// Streaming 3x3 binomial blur (1 2 1 / 2 4 2 / 1 2 1, round half up) with a per-frame
// region-of-interest mask, two line buffers, and an end-of-frame pipeline flush.
module roi_binomial_blur #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int CH    = 3,
  parameter int CW    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic                       startofpacket_in,
  input  logic                       endofpacket_in,
  input  logic [CH*CW-1:0]           data_in,
  input  logic [1:0]                 mode,
  input  logic [$clog2(IMG_W)-1:0]   roi_x0,
  input  logic [$clog2(IMG_W)-1:0]   roi_x1,
  input  logic [$clog2(IMG_H)-1:0]   roi_y0,
  input  logic [$clog2(IMG_H)-1:0]   roi_y1,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       startofpacket_out,
  output logic                       endofpacket_out,
  output logic [CH*CW-1:0]           data_out
);

  localparam int PW = CH * CW;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int D  = IMG_W + 1;
  localparam int KW = $clog2(D + 1);
  localparam int SW = CW + 4;

  // Handshake: an input beat transfers on a clock edge where valid_in && ready_out;
  // an output beat transfers where valid_out && ready_in, and while valid_out is high
  // with ready_in low the output payload is held unchanged.

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state, state_nxt;
  logic            accept, push, restart, flush_step, produce;
  logic [KW-1:0]   in_cnt, flush_cnt;
  logic [XW-1:0]   wptr, out_col;
  logic [YW-1:0]   out_row;
  logic [PW-1:0]   px_in, raw, blur, pix_sel;
  logic [1:0]      f_mode;
  logic [XW-1:0]   f_x0, f_x1;
  logic [YW-1:0]   f_y0, f_y1;
  logic            border, in_roi, want_blur;

  logic [PW-1:0]   lb1 [IMG_W];
  logic [PW-1:0]   lb2 [IMG_W];
  logic [PW-1:0]   win [3][3];
  logic [PW-1:0]   nw  [3][3];

  assign ready_out = ready_in && (state != FLUSH) && rst_n;
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    restart    = 1'b0;
    flush_step = 1'b0;
    case (state)
      IDLE: begin
        if (accept && startofpacket_in) begin
          push      = 1'b1;
          restart   = 1'b1;
          state_nxt = endofpacket_in ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          push    = 1'b1;
          restart = startofpacket_in;
          if (endofpacket_in) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (ready_in) begin
          push       = 1'b1;
          flush_step = 1'b1;
          if (flush_cnt == KW'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A beat only yields output once D pixels are in flight; the restarting sop beat never does.
  assign produce = push && !restart && (in_cnt == KW'(D));
  assign px_in   = flush_step ? '0 : data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_cnt    <= '0;
      flush_cnt <= '0;
      wptr      <= '0;
    end else begin
      state <= state_nxt;
      if (restart)
        in_cnt <= KW'(1);
      else if (push && in_cnt != KW'(D))
        in_cnt <= in_cnt + KW'(1);
      if (state != FLUSH && state_nxt == FLUSH)
        flush_cnt <= KW'(D);
      else if (flush_step)
        flush_cnt <= flush_cnt - KW'(1);
      if (push)
        wptr <= (wptr == XW'(IMG_W - 1)) ? '0 : wptr + XW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_mode <= '0;
      f_x0   <= '0;
      f_x1   <= '0;
      f_y0   <= '0;
      f_y1   <= '0;
    end else if (restart) begin
      f_mode <= mode;
      f_x0   <= roi_x0;
      f_x1   <= roi_x1;
      f_y0   <= roi_y0;
      f_y1   <= roi_y1;
    end
  end

  // Line buffers: read-before-write at wptr gives the word pushed IMG_W beats earlier.
  always_ff @(posedge clk) begin
    if (push) begin
      lb1[wptr] <= px_in;
      lb2[wptr] <= lb1[wptr];
    end
  end

  // nw is the window as it will look after this push; the output is computed from it.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nw[r][0] = win[r][1];
      nw[r][1] = win[r][2];
    end
    nw[0][2] = lb2[wptr];
    nw[1][2] = lb1[wptr];
    nw[2][2] = px_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (push) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= nw[r][c];
    end
  end

  function automatic logic [SW-1:0] ext(input logic [CW-1:0] v);
    return {4'b0000, v};
  endfunction

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [SW-1:0] acc;
    logic [SW-1:0] rnd;
    always_comb begin
      acc = ext(nw[0][0][g*CW +: CW])        + (ext(nw[0][1][g*CW +: CW]) << 1) +
            ext(nw[0][2][g*CW +: CW])        + (ext(nw[1][0][g*CW +: CW]) << 1) +
            (ext(nw[1][1][g*CW +: CW]) << 2) + (ext(nw[1][2][g*CW +: CW]) << 1) +
            ext(nw[2][0][g*CW +: CW])        + (ext(nw[2][1][g*CW +: CW]) << 1) +
            ext(nw[2][2][g*CW +: CW]);
    end
    assign rnd = acc + SW'(8);
    assign blur[g*CW +: CW] = rnd[SW-1:4];
  end

  assign raw    = nw[1][1];
  assign border = (out_row == '0) || (out_row == YW'(IMG_H - 1)) ||
                  (out_col == '0) || (out_col == XW'(IMG_W - 1));
  assign in_roi = (out_col >= f_x0) && (out_col <= f_x1) &&
                  (out_row >= f_y0) && (out_row <= f_y1);

  always_comb begin
    want_blur = 1'b0;
    case (f_mode)
      2'd1:    want_blur = 1'b1;
      2'd2:    want_blur = in_roi;
      2'd3:    want_blur = !in_roi;
      default: want_blur = 1'b0;
    endcase
  end

  assign pix_sel = (want_blur && !border) ? blur : raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_col <= '0;
      out_row <= '0;
    end else if (restart) begin
      out_col <= '0;
      out_row <= '0;
    end else if (produce) begin
      if (out_col == XW'(IMG_W - 1)) begin
        out_col <= '0;
        out_row <= (out_row == YW'(IMG_H - 1)) ? '0 : out_row + YW'(1);
      end else begin
        out_col <= out_col + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out         <= 1'b0;
      data_out          <= '0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
    end else if (produce) begin
      valid_out         <= 1'b1;
      data_out          <= pix_sel;
      startofpacket_out <= (out_row == '0) && (out_col == '0);
      endofpacket_out   <= flush_step && (flush_cnt == KW'(1));
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_roi_binomial_blur.sv
// Bench for roi_binomial_blur on an 8x4 frame of 3x4-bit pixels, checked against a
// per-pixel arithmetic model of the blur/ROI rules.
module tb_roi_binomial_blur;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        clk, rst_n;
  logic        valid_in, ready_out, sop_in, eop_in;
  logic [11:0] data_in;
  logic [1:0]  mode;
  logic [2:0]  roi_x0, roi_x1;
  logic [1:0]  roi_y0, roi_y1;
  logic        valid_out, ready_in, sop_out, eop_out;
  logic [11:0] data_out;

  roi_binomial_blur #(.IMG_W(W), .IMG_H(H), .CH(3), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .startofpacket_in(sop_in), .endofpacket_in(eop_in), .data_in(data_in),
    .mode(mode), .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
    .valid_out(valid_out), .ready_in(ready_in),
    .startofpacket_out(sop_out), .endofpacket_out(eop_out), .data_out(data_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [11:0] img [N];
  int          cfg_m, cfg_x0, cfg_x1, cfg_y0, cfg_y1;
  bit          stall_en = 0, gap_en = 0, scramble_en = 0, in_flush = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // downstream ready: random when stalls are enabled
  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_in = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // output monitor: collects transferred beats and checks hold/flush/reset behaviour
  initial begin
    logic        prev_stall;
    logic [13:0] prev_beat;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_payload", 32'({sop_out, eop_out, data_out}), 0);
        check("rst_ready_out", 32'(ready_out), 0);
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(valid_out), 1);
          check("stall_hold", 32'({sop_out, eop_out, data_out}), 32'(prev_beat));
        end
        if (in_flush) begin
          if (valid_out && eop_out) in_flush = 0;
          else check("flush_ready_out", 32'(ready_out), 0);
        end
        if (valid_out && ready_in) obs_q.push_back({sop_out, eop_out, data_out});
        prev_stall = valid_out && !ready_in;
        prev_beat  = {sop_out, eop_out, data_out};
      end
    end
  end

  // reference model: expected beats p = 0 .. n_exp-1 of a frame of n_in input beats
  function automatic int pix_at(int i, int n_in);
    return (i >= 0 && i < n_in) ? int'(img[i]) : 0;
  endfunction

  task automatic build_exp(input int n_in, input int n_exp);
    for (int p = 0; p < n_exp; p++) begin
      int r, c, res;
      bit brd, inr, blr;
      r   = p / W;
      c   = p % W;
      brd = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
      inr = (c >= cfg_x0) && (c <= cfg_x1) && (r >= cfg_y0) && (r <= cfg_y1);
      blr = (cfg_m == 1) || (cfg_m == 2 && inr) || (cfg_m == 3 && !inr);
      res = int'(img[p]);
      if (blr && !brd) begin
        res = 0;
        for (int ch = 0; ch < 3; ch++) begin
          int sum;
          sum = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              sum += (2 - (dr < 0 ? -dr : dr)) * (2 - (dc < 0 ? -dc : dc)) *
                     ((pix_at(p + dr * W + dc, n_in) >> (4 * ch)) & 15);
          res |= ((sum + 8) / 16) << (4 * ch);
        end
      end
      exp_q.push_back({(p == 0), (p == n_in - 1), 12'(res)});
    end
  endtask

  // driver tasks
  task automatic set_cfg(input int m, input int x0, input int x1, input int y0, input int y1);
    cfg_m = m; cfg_x0 = x0; cfg_x1 = x1; cfg_y0 = y0; cfg_y1 = y1;
    mode = 2'(m); roi_x0 = 3'(x0); roi_x1 = 3'(x1); roi_y0 = 2'(y0); roi_y1 = 2'(y1);
  endtask

  task automatic send_beat(input logic [11:0] d, input logic s, input logic e);
    bit ok, acc;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      valid_in = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    data_in = d; sop_in = s; eop_in = e; valid_in = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = ready_out;
      @(posedge clk);
      #1;
      if (acc) begin ok = 1; break; end
    end
    valid_in = 1'b0;
    check("beat_accepted", 32'(ok), 1);
    if (ok && e) in_flush = 1;
  endtask

  task automatic send_frame(input int n, input bit with_eop);
    for (int k = 0; k < n; k++) begin
      send_beat(img[k], k == 0, with_eop && (k == n - 1));
      if (k == 0 && scramble_en) begin
        mode = 2'($urandom_range(0, 3));
        roi_x0 = 3'($urandom_range(0, 7)); roi_x1 = 3'($urandom_range(0, 7));
        roi_y0 = 2'($urandom_range(0, 3)); roi_y1 = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic check_frame(input string tag);
    int n;
    for (int i = 0; i < 3000 && obs_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_p%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic spot(input string tag, input int idx, input logic [11:0] val);
    check(tag, (idx < obs_q.size()) ? 32'(obs_q[idx][11:0]) : 32'hFFFF_FFFF, 32'(val));
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < N; i++) img[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) img[i] = 12'($urandom_range(0, 4095));
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; data_in = '0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid_out", 32'(valid_out), 0);
    check("reset_data_out", 32'(data_out), 0);
    check("reset_sop_eop", 32'({sop_out, eop_out}), 0);
    check("reset_ready_out", 32'(ready_out), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready_out", 32'(ready_out), 1);

    // constant frame, full blur, with first-output latency
    fill(12'hA5A);
    set_cfg(1, 0, 0, 0, 0);
    build_exp(N, N);
    for (int k = 0; k < N; k++) begin
      send_beat(img[k], k == 0, k == N - 1);
      if (k == 8) check("latency_before", 32'(valid_out), 0);
      if (k == 9) begin
        check("latency_valid", 32'(valid_out), 1);
        check("latency_sop", 32'(sop_out), 1);
        check("latency_data", 32'(data_out), 32'h0A5A);
      end
    end
    check_frame("const");
    clear_q();

    // random frame, full blur
    fill_rand();
    set_cfg(1, 0, 0, 0, 0);
    build_exp(N, N);
    send_frame(N, 1);
    check_frame("rand_full");
    clear_q();

    // impulse, full blur
    fill(12'h000);
    img[1 * W + 1] = 12'hF00;
    set_cfg(1, 0, 0, 0, 0);
    build_exp(N, N);
    send_frame(N, 1);
    check_frame("imp_full");
    spot("imp_1_1", 1 * W + 1, 12'h400);
    spot("imp_1_2", 1 * W + 2, 12'h200);
    spot("imp_2_2", 2 * W + 2, 12'h100);
    spot("imp_0_1", 0 * W + 1, 12'h000);
    clear_q();

    // impulse with ROI inside / outside
    fill(12'h000);
    img[2 * W + 4] = 12'hFFF;
    set_cfg(2, 4, 5, 1, 2);
    build_exp(N, N);
    send_frame(N, 1);
    check_frame("roi_in");
    spot("roi_in_1_4", 1 * W + 4, 12'h222);
    spot("roi_in_1_3", 1 * W + 3, 12'h000);
    spot("roi_in_2_4", 2 * W + 4, 12'h444);
    clear_q();
    set_cfg(3, 4, 5, 1, 2);
    build_exp(N, N);
    send_frame(N, 1);
    check_frame("roi_out");
    spot("roi_out_2_4", 2 * W + 4, 12'hFFF);
    spot("roi_out_1_3", 1 * W + 3, 12'h111);
    clear_q();

    // same impulse under random backpressure and input gaps
    stall_en = 1; gap_en = 1;
    set_cfg(2, 4, 5, 1, 2);
    build_exp(N, N);
    send_frame(N, 1);
    check_frame("roi_stall");
    clear_q();

    // random frames, modes and ROIs; inputs scrambled after sop
    scramble_en = 1;
    for (int it = 0; it < 6; it++) begin
      fill_rand();
      set_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 3));
      build_exp(N, N);
      send_frame(N, 1);
      check_frame($sformatf("rand%0d", it));
      clear_q();
    end
    scramble_en = 0; stall_en = 0; gap_en = 0;

    // reset in the middle of a frame
    fill(12'hA5A);
    set_cfg(1, 0, 0, 0, 0);
    build_exp(N, 3);
    send_frame(12, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", 32'(valid_out), 0);
    check("midrst_data_out", 32'(data_out), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_frame("pre_reset");
    clear_q();
    build_exp(N, N);
    send_frame(N, 1);
    check_frame("after_reset");
    clear_q();

    // IDLE drop, aborted frame restarted by a second sop, then early eop
    stall_en = 1; gap_en = 1;
    for (int i = 0; i < 3; i++) send_beat(12'($urandom_range(0, 4095)), 1'b0, 1'b0);
    fill_rand();
    set_cfg(0, 0, 0, 0, 0);
    send_frame(5, 0);
    fill_rand();
    set_cfg(1, 0, 0, 0, 0);
    build_exp(N, N);
    send_frame(N, 1);
    check_frame("restart");
    clear_q();
    fill_rand();
    set_cfg(3, 2, 5, 1, 1);
    build_exp(20, 20);
    send_frame(20, 1);
    check_frame("early_eop");
    clear_q();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
